// File: rtl/gate_stimulus_counter_if.sv
// rtl/gate_stimulus_counter_if.sv - control/status bundle for the gate stimulus counter
interface gate_stimulus_counter_if #(
  parameter int WIDTH = 4
) ();
  logic             en;
  logic             mode;
  logic             up_dn;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             step_btn;
  logic [WIDTH-1:0] count;
  logic             gate_a;
  logic             gate_b;
  logic             tick;
  logic             tc;

  modport master (
    output en, mode, up_dn, load, load_val, step_btn,
    input  count, gate_a, gate_b, tick, tc
  );

  modport slave (
    input  en, mode, up_dn, load, load_val, step_btn,
    output count, gate_a, gate_b, tick, tc
  );
endinterface

// File: rtl/gate_stimulus_counter.sv
// rtl/gate_stimulus_counter.sv - up/down stimulus counter driving gate inputs A/B
// Optional push-button debounce is enabled by defining STEP_DEBOUNCE_EN.
module gate_stimulus_counter #(
  parameter int WIDTH        = 4,
  parameter int TICK_DIV     = 50_000_000,
  parameter int DEBOUNCE_CYC = 1_000_000
) (
  input logic                   clk,
  input logic                   rst_n,
  gate_stimulus_counter_if.slave bus
);
  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  if (WIDTH < 2 || TICK_DIV < 2 || DEBOUNCE_CYC < 2) begin : g_param_check
    $error("gate_stimulus_counter: WIDTH, TICK_DIV and DEBOUNCE_CYC must all be >= 2");
  end

  logic [PW-1:0]    presc;
  logic             tick_q;
  logic [WIDTH-1:0] count_q;
  logic             tc_q;
  logic             sync1;
  logic             sync2;
  logic             btn_lvl;
  logic             lvl_d;
  logic             step;
  logic             adv;

  // Load restarts the tick period so the next tick lands a full period after the load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc  <= '0;
      tick_q <= 1'b0;
    end else if (bus.load) begin
      presc  <= '0;
      tick_q <= 1'b0;
    end else if (bus.en) begin
      tick_q <= (presc == PW'(TICK_DIV - 1));
      presc  <= (presc == PW'(TICK_DIV - 1)) ? '0 : presc + 1'b1;
    end else begin
      tick_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      lvl_d <= 1'b0;
    end else begin
      sync1 <= bus.step_btn;
      sync2 <= sync1;
      lvl_d <= btn_lvl;
    end
  end

`ifdef STEP_DEBOUNCE_EN
  localparam int DW = $clog2(DEBOUNCE_CYC);

  logic [DW-1:0] db_cnt;
  logic          db_lvl;

  // A new level must persist DEBOUNCE_CYC consecutive cycles; any return resets the run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt <= '0;
      db_lvl <= 1'b0;
    end else if (sync2 == db_lvl) begin
      db_cnt <= '0;
    end else if (db_cnt == DW'(DEBOUNCE_CYC - 1)) begin
      db_cnt <= '0;
      db_lvl <= sync2;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  assign btn_lvl = db_lvl;
`else
  assign btn_lvl = sync2;
`endif

  assign step = btn_lvl & ~lvl_d;
  assign adv  = bus.en & (bus.mode ? step : tick_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      tc_q    <= 1'b0;
    end else if (bus.load) begin
      count_q <= bus.load_val;
      tc_q    <= 1'b0;
    end else if (adv) begin
      if (bus.up_dn) begin
        count_q <= count_q + 1'b1;
        tc_q    <= &count_q;
      end else begin
        count_q <= count_q - 1'b1;
        tc_q    <= ~|count_q;
      end
    end else begin
      tc_q <= 1'b0;
    end
  end

  assign bus.count  = count_q;
  assign bus.gate_a = count_q[1];
  assign bus.gate_b = count_q[0];
  assign bus.tick   = tick_q;
  assign bus.tc     = tc_q;
endmodule
